// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer.
// Op encodings and op-field width.
package pc_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } op_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control <-> PC sequencer bundle.
// master = fetch control, slave = sequencer.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             en;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] next_pc;
    logic             stack_full;
    logic             stack_empty;
    logic             err;
    logic [WIDTH-1:0] trace_out;

    modport master (
        output en, op, target, offset,
        input  pc_out, next_pc, stack_full,
        input  stack_empty, err, trace_out
    );

    modport slave (
        input  en, op, target, offset,
        output pc_out, next_pc, stack_full,
        output stack_empty, err, trace_out
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full
// overwrites the oldest entry.
module ras_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign overflow  = push && full;
    assign underflow = pop && empty;
    // ptr is the next write slot; the top sits just below it
    assign top       = mem[ptr - PW'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Parametrised PC sequencer with jumps and CALL/RET stack.
// Optional PC trace shift register: define PC_TRACE_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STEP        = 1,
    parameter int RESET_PC    = 0,
    parameter int STACK_DEPTH = 4,
    parameter int TRACE_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    pc_sequencer_if.slave bus
);

    localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_PC);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] top;
    logic             err_q;
    logic             do_inc;
    logic             do_load;
    logic             do_branch;
    logic             do_call;
    logic             do_ret;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    assign do_inc    = bus.en && (bus.op == OP_INC);
    assign do_load   = bus.en && (bus.op == OP_LOAD);
    assign do_branch = bus.en && (bus.op == OP_BRANCH);
    assign do_call   = bus.en && (bus.op == OP_CALL);
    assign do_ret    = bus.en && (bus.op == OP_RET);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (do_call),
        .pop       (do_ret),
        .push_data (pc_q + STEP_V),
        .top       (top),
        .full      (full),
        .empty     (empty),
        .overflow  (ovf),
        .underflow (unf)
    );

    always_comb begin
        nxt = pc_q;
        unique case (1'b1)
            do_inc:           nxt = pc_q + STEP_V;
            do_load, do_call: nxt = bus.target;
            do_branch:        nxt = pc_q + bus.offset;
            do_ret:           nxt = empty ? pc_q : top;
            default:          nxt = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_V;
            err_q <= 1'b0;
        end else begin
            pc_q  <= nxt;
            err_q <= ovf || unf;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.next_pc     = nxt;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.err         = err_q;

`ifdef PC_TRACE_EN
    logic [WIDTH-1:0] trace_q [TRACE_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_q[i] <= '0;
            end
        end else if (bus.en) begin
            trace_q[0] <= pc_q;
            for (int i = 1; i < TRACE_DEPTH; i++) begin
                trace_q[i] <= trace_q[i-1];
            end
        end
    end

    assign bus.trace_out = trace_q[TRACE_DEPTH-1];
`else
    assign bus.trace_out = '0;
`endif

endmodule
